// File: rtl/cola_dispense_ctrl.sv
// cola_dispense_ctrl: queues cola/coin requests and runs one shared-supply motor at a time.
module cola_dispense_ctrl #(
    parameter int MOTOR_CYC   = 50,
    parameter int TIMEOUT_CYC = 200,
    parameter int PEND_W      = 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pi_cola,
    input  logic              pi_change,
    input  logic              pi_sensor_cola,
    input  logic              pi_sensor_coin,
    input  logic              pi_err_clr,
    output logic              po_motor_cola,
    output logic              po_motor_coin,
    output logic              po_busy,
    output logic              po_err,
    output logic              po_ovf,
    output logic [PEND_W-1:0] po_cola_pend,
    output logic [PEND_W-1:0] po_coin_pend
);
    localparam int TMAX = (MOTOR_CYC > TIMEOUT_CYC) ? MOTOR_CYC : TIMEOUT_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [5:0] IDLE      = 6'b000001;
    localparam logic [5:0] COLA_RUN  = 6'b000010;
    localparam logic [5:0] COLA_WAIT = 6'b000100;
    localparam logic [5:0] COIN_RUN  = 6'b001000;
    localparam logic [5:0] COIN_WAIT = 6'b010000;
    localparam logic [5:0] ERR       = 6'b100000;
    localparam logic [PEND_W-1:0] PMAX     = '1;
    localparam logic [TW-1:0]     RUN_LAST = TW'(MOTOR_CYC - 1);
    localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [5:0]        state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] cola_pend_q, cola_pend_d, coin_pend_q, coin_pend_d;
    logic              last_cola_q, last_cola_d;
    logic              seen_q, seen_d;
    logic              motor_cola_q, motor_cola_d, motor_coin_q, motor_coin_d;
    logic              ovf_q, ovf_d;
    logic [2:0]        sync_cola_q, sync_cola_d, sync_coin_q, sync_coin_d;
    logic              edge_cola, edge_coin, edge_act;
    logic              grant_cola, grant_coin, cola_inc, coin_inc;

    always_comb begin
        sync_cola_d = {sync_cola_q[1:0], pi_sensor_cola};
        sync_coin_d = {sync_coin_q[1:0], pi_sensor_coin};
        edge_cola   = sync_cola_q[1] & ~sync_cola_q[2];
        edge_coin   = sync_coin_q[1] & ~sync_coin_q[2];
        // only the channel currently being dispensed may complete the wait
        edge_act    = (state_q == COLA_RUN || state_q == COLA_WAIT) ? edge_cola : edge_coin;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        seen_d      = 1'b0;
        last_cola_d = last_cola_q;
        grant_cola  = 1'b0;
        grant_coin  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d    = '0;
                grant_cola = (cola_pend_q != '0) && ((coin_pend_q == '0) || !last_cola_q);
                grant_coin = !grant_cola && (coin_pend_q != '0);
                state_d    = grant_cola ? COLA_RUN : grant_coin ? COIN_RUN : IDLE;
                last_cola_d = grant_cola ? 1'b1 : grant_coin ? 1'b0 : last_cola_q;
            end
            COLA_RUN, COIN_RUN: begin
                seen_d  = seen_q | edge_act;
                timer_d = (timer_q == RUN_LAST) ? '0 : timer_q + TW'(1);
                state_d = (timer_q != RUN_LAST) ? state_q : (state_q == COLA_RUN) ? COLA_WAIT : COIN_WAIT;
            end
            COLA_WAIT, COIN_WAIT: begin
                timer_d = (seen_q || edge_act || timer_q == TO_LAST) ? '0 : timer_q + TW'(1);
                state_d = (seen_q || edge_act) ? IDLE : (timer_q == TO_LAST) ? ERR : state_q;
            end
            ERR:     state_d = pi_err_clr ? IDLE : ERR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cola_inc     = pi_cola & (cola_pend_q != PMAX);
        coin_inc     = pi_change & (coin_pend_q != PMAX);
        cola_pend_d  = cola_pend_q + PEND_W'(cola_inc) - PEND_W'(grant_cola);
        coin_pend_d  = coin_pend_q + PEND_W'(coin_inc) - PEND_W'(grant_coin);
        ovf_d        = (ovf_q & ~pi_err_clr) | (pi_cola & ~cola_inc) | (pi_change & ~coin_inc);
        motor_cola_d = (state_d == COLA_RUN);
        motor_coin_d = (state_d == COIN_RUN);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cola_pend_q  <= '0;
            coin_pend_q  <= '0;
            last_cola_q  <= 1'b0;
            seen_q       <= 1'b0;
            motor_cola_q <= 1'b0;
            motor_coin_q <= 1'b0;
            ovf_q        <= 1'b0;
            sync_cola_q  <= '0;
            sync_coin_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cola_pend_q  <= cola_pend_d;
            coin_pend_q  <= coin_pend_d;
            last_cola_q  <= last_cola_d;
            seen_q       <= seen_d;
            motor_cola_q <= motor_cola_d;
            motor_coin_q <= motor_coin_d;
            ovf_q        <= ovf_d;
            sync_cola_q  <= sync_cola_d;
            sync_coin_q  <= sync_coin_d;
        end
    end

    assign po_motor_cola = motor_cola_q;
    assign po_motor_coin = motor_coin_q;
    assign po_busy       = (state_q != IDLE);
    assign po_err        = (state_q == ERR);
    assign po_ovf        = ovf_q;
    assign po_cola_pend  = cola_pend_q;
    assign po_coin_pend  = coin_pend_q;
endmodule
